// File: rtl/cgate_meter_pkg.sv
// Shared types and defaults for the C-gate ring meter.
// The continuous mode is selected by CGATE_RING_METER_CONTINUOUS_EN in the top.
package cgate_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meter_state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WINDOW_LOG2 = 10;
  localparam int DEF_SYNC_STAGES = 2;

  // Largest value representable in w bits, clamped to 32 bits.
  function automatic logic [31:0] satMax(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cgate_meter_sync.sv
// Multi-stage synchronizer for all ring inputs plus per-channel rising-edge detect.
module cgate_meter_sync
  import cgate_meter_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_async,
  output logic [NUM_CH-1:0] o_sync,
  output logic [NUM_CH-1:0] o_rise
);

  logic [NUM_CH-1:0] r_stage [SYNC_STAGES];
  logic [NUM_CH-1:0] r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
      r_prev <= '0;
    end else begin
      r_stage[0] <= i_async;
      for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
      r_prev <= r_stage[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;

endmodule

// File: rtl/cgate_ring_meter.sv
// Gated rising-edge counter for one selected asynchronous ring/C-gate output.
// Define CGATE_RING_METER_CONTINUOUS_EN to repeat windows while start stays high.
module cgate_ring_meter
  import cgate_meter_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ring_in,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam int PH_W  = (WINDOW_LOG2 > ARM_W) ? WINDOW_LOG2 : ARM_W;
  localparam logic [PH_W-1:0]  L_ARM_LAST  = PH_W'(SYNC_STAGES);
  localparam logic [PH_W-1:0]  L_GATE_LAST = PH_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [CNT_W-1:0] L_CNT_MAX   = CNT_W'(satMax(CNT_W));

  meter_state_e      r_state;
  meter_state_e      w_nextState;
  logic [CH_W-1:0]   r_ch;
  logic [PH_W-1:0]   r_phase;
  logic [CNT_W-1:0]  r_work;
  logic              r_workOvf;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;

  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_rise;
  logic [CH_W-1:0]   w_chMapped;
  logic              w_selRise;
  logic              w_armLast;
  logic              w_gateLast;
  logic              w_atMax;
  logic [CNT_W-1:0]  w_workNext;
  logic              w_ovfNext;

  cgate_meter_sync #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (ring_in),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_chMapped = (32'(ch_sel) >= NUM_CH) ? '0 : ch_sel;
  assign w_selRise  = w_rise[r_ch] & w_sync[r_ch];
  assign w_armLast  = (r_phase == L_ARM_LAST);
  assign w_gateLast = (r_phase == L_GATE_LAST);
  assign w_atMax    = (r_work == L_CNT_MAX);
  assign w_workNext = (w_selRise && !w_atMax) ? r_work + CNT_W'(1) : r_work;
  assign w_ovfNext  = r_workOvf | (w_selRise & w_atMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = ARM;
      end
      ARM:  if (w_armLast) w_nextState = GATE;
      GATE: if (w_gateLast) w_nextState = DONE;
      DONE: begin
        done = 1'b1;
`ifdef CGATE_RING_METER_CONTINUOUS_EN
        w_nextState = start ? ARM : IDLE;
`else
        w_nextState = IDLE;
`endif
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Results are loaded with the last gate cycle's edge included, so they are
  // already valid during the DONE cycle alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch      <= '0;
      r_phase   <= '0;
      r_work    <= '0;
      r_workOvf <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_phase <= '0;
          if (start) r_ch <= w_chMapped;
        end
        ARM: begin
          r_work    <= '0;
          r_workOvf <= 1'b0;
          r_phase   <= w_armLast ? '0 : r_phase + PH_W'(1);
        end
        GATE: begin
          r_work    <= w_workNext;
          r_workOvf <= w_ovfNext;
          r_phase   <= w_gateLast ? '0 : r_phase + PH_W'(1);
          if (w_gateLast) begin
            r_count <= w_workNext;
            r_ovf   <= w_ovfNext;
          end
        end
        default: r_phase <= '0;
      endcase
    end
  end

  assign count    = r_count;
  assign overflow = r_ovf;

endmodule
